mem_burst_reader: RTL and testbench

Read-side initiator for the single-port byte-enable memory: accepts a burst read request (base address, length), drives the memory's combinational read address, and registers each returned word into an output stage. Words stream to the consumer over valid/ready with a last flag. Sits between the memory's read port and DMA or streaming consumers. The output register isolates the memory access path from downstream logic.

---
 rtl/mem_burst_reader.sv | 101 ++++++++++
 tb/tb_mem_burst_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// mem_burst_reader
// Read-side burst initiator for a single-port memory with a combinational
// read path. A request (base address, beat count) is accepted in IDLE. The
// block then walks the memory address and registers each returned word into a
// one-deep output stage. The words stream out over valid/ready with a last flag.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-high reset
//   reqValid/Ready  burst request handshake; reqReady only in IDLE, not in reset
//   reqAddr         burst base word address
//   reqLen          beat count; 0 is a null request, values above MaxBurst clamp
//   memReadAddr     registered read address to the memory
//   memReadData     combinational read data for memReadAddr
//   outValid/Ready  output beat handshake
//   outData         registered beat data
//   outLast         final beat of the burst (0 whenever outValid is 0)
//   busy            high whenever a burst is in progress
module mem_burst_reader #(
    parameter  int NumEntries = 256,
    parameter  int DataWidth  = 32,
    parameter  int MaxBurst   = 16,
    localparam int AddrWidth  = $clog2(NumEntries),
    localparam int LenWidth   = $clog2(MaxBurst + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic [AddrWidth-1:0] reqAddr,
    input  logic [LenWidth-1:0]  reqLen,
    output logic [AddrWidth-1:0] memReadAddr,
    input  logic [DataWidth-1:0] memReadData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [DataWidth-1:0] outData,
    output logic                 outLast,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state;
    logic [LenWidth-1:0] remaining;
    logic [LenWidth-1:0] clampLen;
    logic [AddrWidth-1:0] nextAddr;
    logic                cap;

    assign clampLen = (reqLen > LenWidth'(MaxBurst)) ? LenWidth'(MaxBurst) : reqLen;

    // Explicit wrap so a non-power-of-two depth still returns to 0.
    assign nextAddr = (memReadAddr == AddrWidth'(NumEntries - 1)) ? '0
                                                                   : memReadAddr + 1'b1;

    // The output stage can take a new word when it is empty or is being drained.
    assign cap = !outValid || outReady;

    assign reqReady = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            memReadAddr <= '0;
            outValid    <= 1'b0;
            outData     <= '0;
            outLast     <= 1'b0;
            remaining   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero-length request is consumed here without any beats.
                    if (reqValid && reqLen != '0) begin
                        memReadAddr <= reqAddr;
                        remaining   <= clampLen;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (cap) begin
                        outData     <= memReadData;
                        outValid    <= 1'b1;
                        outLast     <= (remaining == LenWidth'(1));
                        memReadAddr <= nextAddr;
                        remaining   <= remaining - 1'b1;
                        if (remaining == LenWidth'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outValid && outReady) begin
                        outValid <= 1'b0;
                        outLast  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
module tb_mem_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqAddr;
    logic [4:0]  reqLen;
    logic [7:0]  memReadAddr;
    logic [31:0] memReadData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic        outLast;
    logic        busy;

    // Memory model: combinational read, write on posedge, preloaded during reset.
    logic [31:0] mem [256];
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int nchk  = 0;
    int nfail = 0;
    bit stall_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= i * 32'h01010101;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign memReadData = mem[memReadAddr];

    mem_burst_reader dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqLen(reqLen),
        .memReadAddr(memReadAddr), .memReadData(memReadData),
        .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and collect every beat, checking data, order, last flag,
    // stall stability and (without stalls) back-to-back timing.
    task automatic burst(input string tag, input logic [7:0] addr, input logic [4:0] len,
                         input int nbeats, input bit stall);
        int          got = 0;
        int          cyc = 0;
        bit          held = 0;
        logic [31:0] hold_d = '0;
        logic        hold_l = 1'b0;
        logic [7:0]  a;
        chk({tag, " reqReady"}, {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1; reqAddr = addr; reqLen = len;
        tick();
        // Later request fields must be ignored.
        reqValid = 1'b0; reqAddr = 8'hA5; reqLen = 5'd3;
        chk({tag, " busy"}, {31'b0, busy}, 32'd1);
        chk({tag, " lat"}, {31'b0, outValid}, 32'd0);
        while (got < nbeats && cyc < 300) begin
            outReady = stall ? stall_pat[cyc % 6] : 1'b1;
            if (outValid) begin
                if (held) begin
                    chk({tag, " hold data"}, outData, hold_d);
                    chk({tag, " hold last"}, {31'b0, outLast}, {31'b0, hold_l});
                end
                if (outReady) begin
                    a = addr + 8'(got);
                    chk({tag, " data"}, outData, mem[a]);
                    chk({tag, " last"}, {31'b0, outLast}, {31'b0, (got == nbeats - 1)});
                    if (!stall) chk({tag, " timing"}, cyc, got + 1);
                    got++;
                    held = 0;
                end else begin
                    held = 1; hold_d = outData; hold_l = outLast;
                end
            end
            tick();
            cyc++;
        end
        outReady = 1'b1;
        chk({tag, " beats"}, got, nbeats);
        chk({tag, " done valid"}, {31'b0, outValid}, 32'd0);
        chk({tag, " done busy"}, {31'b0, busy}, 32'd0);
        chk({tag, " done last"}, {31'b0, outLast}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; reqValid = 1'b0; reqAddr = '0; reqLen = '0; outReady = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        chk("rst reqReady", {31'b0, reqReady}, 32'd0);
        chk("rst addr", {24'b0, memReadAddr}, 32'd0);
        chk("rst valid", {31'b0, outValid}, 32'd0);
        chk("rst data", outData, 32'd0);
        chk("rst last", {31'b0, outLast}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle reqReady", {31'b0, reqReady}, 32'd1);

        // Basic burst, explicit values.
        chk("mem10 model", mem[8'h10], 32'h10101010);
        burst("basic", 8'h10, 5'd4, 4, 1'b0);
        chk("addr hold", {24'b0, memReadAddr}, 32'h14);

        // Same burst with a stalling consumer.
        burst("stall", 8'h10, 5'd4, 4, 1'b1);

        // Address wrap 254,255,0,1.
        burst("wrap", 8'd254, 5'd4, 4, 1'b0);
        chk("wrap addr", {24'b0, memReadAddr}, 32'd2);

        // Null request: consumed, no beats, ready again next cycle.
        reqValid = 1'b1; reqAddr = 8'h30; reqLen = 5'd0;
        tick();
        reqValid = 1'b0;
        chk("null busy", {31'b0, busy}, 32'd0);
        chk("null reqReady", {31'b0, reqReady}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("null valid", {31'b0, outValid}, 32'd0);
            tick();
        end

        // Clamp: 31 requested, 16 delivered.
        burst("clamp", 8'h20, 5'd31, 16, 1'b0);
        tick(); tick();
        chk("clamp extra", {31'b0, outValid}, 32'd0);

        // Reset in the middle of an 8-beat burst.
        reqValid = 1'b1; reqAddr = 8'h50; reqLen = 5'd8;
        tick();
        reqValid = 1'b0;
        tick();
        chk("mid beat0", outData, 32'h50505050);
        tick();
        chk("mid beat1", outData, 32'h51515151);
        rst = 1'b1;
        #1;
        chk("mid rst reqReady", {31'b0, reqReady}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid valid", {31'b0, outValid}, 32'd0);
        chk("mid busy", {31'b0, busy}, 32'd0);
        chk("mid reqReady", {31'b0, reqReady}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid no beats", {31'b0, outValid}, 32'd0);
        end
        burst("after rst", 8'h00, 5'd2, 2, 1'b0);

        // Collision: overwrite the address being captured in the same cycle.
        reqValid = 1'b1; reqAddr = 8'h40; reqLen = 5'd4;
        tick();
        reqValid = 1'b0;
        chk("col addr", {24'b0, memReadAddr}, 32'h40);
        wr_en = 1'b1; wr_addr = 8'h40; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        chk("col old", outData, 32'h40404040);
        chk("col valid", {31'b0, outValid}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("col data", outData, 32'h40404040 + 32'(i) * 32'h01010101);
            chk("col last", {31'b0, outLast}, {31'b0, (i == 3)});
        end
        tick();
        chk("col done", {31'b0, busy}, 32'd0);
        reqValid = 1'b1; reqAddr = 8'h40; reqLen = 5'd1;
        tick();
        reqValid = 1'b0;
        tick();
        chk("col reread", outData, 32'hDEADBEEF);
        chk("col reread last", {31'b0, outLast}, 32'd1);
        tick();
        chk("col reread done", {31'b0, outValid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
